// File: rtl/bouncing_rect_gen.sv
// rtl/bouncing_rect_gen.sv - N coloured rectangles bouncing inside the active area
// Registers RGB and re-times hsync/vsync by one pixel so the PMOD outputs stay aligned.
module bouncing_rect_gen #(
  parameter int          N_RECT   = 2,
  parameter int          RECT_W   = 64,
  parameter int          RECT_H   = 48,
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter logic [23:0] COLORS   = 24'b001111_110000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       video_active,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       pause,
  input  logic [1:0] speed,
  output logic [5:0] rgb,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [7:0] bounce_cnt
);

  localparam logic [10:0] X_LIM = 11'(H_ACTIVE - RECT_W);
  localparam logic [10:0] Y_LIM = 11'(V_ACTIVE - RECT_H);

  typedef struct packed {
    logic [10:0] pos;
    logic        neg;
    logic        hit;
  } axis_t;

  // One axis move with a clamp at either wall; the direction flips on the clamp.
  function automatic axis_t axis_step(input logic [10:0] pos, input logic neg,
                                      input logic [10:0] step, input logic [10:0] lim);
    axis_t r;
    r.pos = pos;
    r.neg = neg;
    r.hit = 1'b0;
    if (!neg) begin
      if (pos + step > lim) begin
        r.pos = lim;
        r.neg = 1'b1;
        r.hit = 1'b1;
      end else begin
        r.pos = pos + step;
      end
    end else if (pos < step) begin
      r.pos = '0;
      r.neg = 1'b0;
      r.hit = 1'b1;
    end else begin
      r.pos = pos - step;
    end
    return r;
  endfunction

  logic [10:0] rx     [N_RECT];
  logic [10:0] ry     [N_RECT];
  logic        dx_neg [N_RECT];
  logic        dy_neg [N_RECT];
  axis_t       nx     [N_RECT];
  axis_t       ny     [N_RECT];
  logic        any_hit;
  logic        update;
  logic [10:0] step;
  logic [10:0] px;
  logic [10:0] py;
  logic [5:0]  rgb_next;

  assign step   = 11'(speed) + 11'd1;
  assign px     = {1'b0, pix_x};
  assign py     = {1'b0, pix_y};
  assign update = (px == 11'd0) && (py == 11'(V_ACTIVE));

  always_comb begin
    any_hit = 1'b0;
    for (int i = 0; i < N_RECT; i++) begin
      nx[i]   = axis_step(rx[i], dx_neg[i], step, X_LIM);
      ny[i]   = axis_step(ry[i], dy_neg[i], step, Y_LIM);
      any_hit = any_hit | nx[i].hit | ny[i].hit;
    end
  end

  // Scan from the highest index down so the lowest-index rectangle wins overlaps.
  always_comb begin
    rgb_next = '0;
    for (int i = N_RECT - 1; i >= 0; i--) begin
      if (px >= rx[i] && px < rx[i] + 11'(RECT_W) &&
          py >= ry[i] && py < ry[i] + 11'(RECT_H))
        rgb_next = COLORS[6*i +: 6];
    end
    if (!video_active)
      rgb_next = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_RECT; i++) begin
        rx[i]     <= 11'(i * 2 * RECT_W);
        ry[i]     <= 11'(i * RECT_H);
        dx_neg[i] <= 1'b0;
        dy_neg[i] <= 1'b0;
      end
      rgb        <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      bounce_cnt <= '0;
    end else begin
      rgb       <= rgb_next;
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
      if (update && !pause) begin
        for (int i = 0; i < N_RECT; i++) begin
          rx[i]     <= nx[i].pos;
          ry[i]     <= ny[i].pos;
          dx_neg[i] <= nx[i].neg;
          dy_neg[i] <= ny[i].neg;
        end
        if (any_hit)
          bounce_cnt <= bounce_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bouncing_rect_gen.sv
// tb/tb_bouncing_rect_gen.sv - directed bench for bouncing_rect_gen with a reference model
module tb_bouncing_rect_gen;

  localparam int XL = 576;
  localparam int YL = 432;
  localparam logic [5:0] C0 = 6'b110000;
  localparam logic [5:0] C1 = 6'b001111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pix_x, pix_y;
  logic       video_active, hsync_in, vsync_in, pause;
  logic [1:0] speed;
  logic [5:0] rgb;
  logic       hsync_out, vsync_out;
  logic [7:0] bounce_cnt;

  always #5 clk = ~clk;

  bouncing_rect_gen dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .video_active(video_active), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pause(pause), .speed(speed), .rgb(rgb), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .bounce_cnt(bounce_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  int mx[2], my[2], mdx[2], mdy[2];
  int bcnt, bounce_frames;
  logic [5:0] col[2];
  logic [5:0] exp_rgb;
  logic       exp_hs, exp_vs;
  logic [7:0] exp_bc;
  bit         check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = i * 128; my[i] = i * 48; mdx[i] = 1; mdy[i] = 1;
    end
    bcnt = 0;
    bounce_frames = 0;
  endtask

  // Signed move then reflect off whichever wall was crossed.
  task automatic model_update();
    int s;
    bit hit;
    s = int'(speed) + 1;
    hit = 0;
    for (int i = 0; i < 2; i++) begin
      mx[i] += mdx[i] * s;
      if (mx[i] > XL) begin mx[i] = XL; mdx[i] = -1; hit = 1; end
      else if (mx[i] < 0) begin mx[i] = 0; mdx[i] = 1; hit = 1; end
      my[i] += mdy[i] * s;
      if (my[i] > YL) begin my[i] = YL; mdy[i] = -1; hit = 1; end
      else if (my[i] < 0) begin my[i] = 0; mdy[i] = 1; hit = 1; end
    end
    if (hit) begin
      bcnt = (bcnt + 1) % 256;
      bounce_frames++;
    end
  endtask

  function automatic logic [5:0] model_color(input int px, input int py, input bit act);
    if (!act) return 6'd0;
    for (int i = 0; i < 2; i++)
      if (px >= mx[i] && px < mx[i] + 64 && py >= my[i] && py < my[i] + 48)
        return col[i];
    return 6'd0;
  endfunction

  task automatic tick(input int px, input int py, input bit act, input bit hs, input bit vs);
    pix_x = 10'(px); pix_y = 10'(py);
    video_active = act; hsync_in = hs; vsync_in = vs;
    if (!rst_n) begin
      model_reset();
      exp_rgb = '0; exp_hs = 1'b0; exp_vs = 1'b0;
    end else begin
      exp_rgb = model_color(px, py, act);
      exp_hs = hs; exp_vs = vs;
      if (px == 0 && py == 480 && !pause) model_update();
    end
    exp_bc = 8'(bcnt);
    check_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic upd();
    tick(0, 480, 0, 0, 1);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick(3, 3, 1, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic probe_rect(input int i);
    int x, y;
    x = mx[i]; y = my[i];
    tick(x, y, 1, 0, 0);
    tick(x + 63, y + 47, 1, 1, 0);
    if (x > 0) tick(x - 1, y, 1, 0, 1);
    if (x + 64 < 640) tick(x + 64, y + 47, 1, 0, 0);
    if (y > 0) tick(x + 63, y - 1, 1, 1, 1);
    if (y + 48 < 480) tick(x, y + 48, 1, 0, 0);
  endtask

  always @(posedge clk) begin
    if (check_en) begin
      #1;
      check("rgb", rgb, exp_rgb);
      check("hsync_out", hsync_out, exp_hs);
      check("vsync_out", vsync_out, exp_vs);
      check("bounce_cnt", bounce_cnt, exp_bc);
    end
  end

  initial begin
    bit found;
    int px, py;
    col[0] = C0; col[1] = C1;
    rst_n = 1'b0; pix_x = '0; pix_y = '0; video_active = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; pause = 1'b0; speed = 2'd0;
    model_reset();
    @(negedge clk);

    // Reset state and static hit test
    tick(5, 5, 1, 1, 0);
    tick(5, 5, 1, 0, 1);
    rst_n = 1'b1;
    tick(10, 10, 1, 1, 0);
    check("t1_rgb_10_10", rgb, C0);
    tick(130, 50, 1, 0, 1);
    check("t1_rgb_130_50", rgb, C1);
    tick(10, 10, 0, 0, 0);
    check("t1_blank", rgb, 6'd0);

    // Step size follows speed
    speed = 2'd0; upd();
    check("t2_x0_after_1", mx[0], 1);
    check("t2_y0_after_1", my[0], 1);
    probe_rect(0); probe_rect(1);
    speed = 2'd3; upd();
    check("t2_x0_after_2", mx[0], 5);
    check("t2_y0_after_2", my[0], 5);
    probe_rect(0); probe_rect(1);

    // Wall bounces at speed 3 from reset
    reset_dut();
    speed = 2'd3;
    for (int k = 1; k <= 145; k++) begin
      upd();
      probe_rect(0); probe_rect(1);
      if (k == 108) begin
        check("t3_y0_108", my[0], 432);
        check("t3_bc_108", bcnt, 1);
      end
      if (k == 109) begin
        check("t3_y0_109", my[0], 432);
        check("t3_dy0_109", mdy[0], -1);
        check("t3_dut_bc_109", bounce_cnt, 8'd2);
      end
      if (k == 110) check("t3_y0_110", my[0], 428);
      if (k == 144) begin
        check("t3_x0_144", mx[0], 576);
        check("t3_bc_144", bcnt, 3);
      end
      if (k == 145) begin
        check("t3_x0_145", mx[0], 576);
        check("t3_dx0_145", mdx[0], -1);
        check("t3_dut_bc_145", bounce_cnt, 8'd4);
      end
    end

    // Pause freezes motion and the counter, sync still passes through
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      upd();
      tick(200, 200, 1, k[0], ~k[0]);
      check("t4_hsync", hsync_out, k[0]);
    end
    check("t4_dut_bc", bounce_cnt, 8'd4);
    check("t4_x0", mx[0], 576);
    probe_rect(0); probe_rect(1);
    pause = 1'b0;

    // Run at speed 0 until the rectangles overlap, then test priority
    reset_dut();
    speed = 2'd0;
    found = 0;
    for (int k = 0; k < 2500; k++) begin
      upd();
      if ((mx[0] - mx[1] < 64) && (mx[1] - mx[0] < 64) &&
          (my[0] - my[1] < 48) && (my[1] - my[0] < 48)) begin
        found = 1;
        break;
      end
    end
    check("t5_overlap_reached", found, 1);
    if (found) begin
      px = (mx[0] > mx[1]) ? mx[0] : mx[1];
      py = (my[0] > my[1]) ? my[0] : my[1];
      tick(px, py, 1, 0, 0);
      check("t5_overlap_rgb", rgb, C0);
      tick(px, py, 0, 0, 0);
      check("t5_overlap_inactive", rgb, 6'd0);
      probe_rect(0); probe_rect(1);
    end

    // Mid-frame reset, then bounce counter wrap
    speed = 2'd3;
    for (int k = 0; k < 50; k++) upd();
    rst_n = 1'b0;
    tick(100, 100, 1, 1, 1);
    check("t6_rst_bc", bounce_cnt, 8'd0);
    check("t6_rst_hsync", hsync_out, 1'b0);
    rst_n = 1'b1;
    tick(0, 0, 1, 0, 0);
    check("t6_start_rect0", rgb, C0);
    tick(128, 48, 1, 0, 0);
    check("t6_start_rect1", rgb, C1);
    tick(127, 47, 1, 0, 0);
    check("t6_start_gap", rgb, 6'd0);
    found = 0;
    for (int k = 0; k < 20000; k++) begin
      upd();
      if (bounce_frames == 256) begin
        found = 1;
        break;
      end
    end
    check("t6_256_bounces", found, 1);
    check("t6_wrap_dut", bounce_cnt, 8'd0);
    probe_rect(0); probe_rect(1);

    check_en = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
